fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the pipelined MIPS core. Owns the PC register and issues one instruction-memory request at a time through a req/ack handshake. Applies the next-PC redirect from the decode stage after the branch delay slot. Fills the IF/ID pipeline register, honours hazard stalls, and flushes on exception or `eret`, so the NPC adder/mux never has to track sequencing state.

## Interface
- `RESET_PC`, 32'h0000_3000: first fetch address after reset.
- `EXC_PC`, 32'h0000_4180: exception handler entry.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in 1: hazard unit holds IF/ID and PC.
- `redir_valid_i` in 1: ID holds a taken branch or jump (1-cycle pulse per instruction).
- `redir_pc_i` in 32: NPC target.
- `exc_valid_i` in 1: exception flush pulse.
- `eret_valid_i` in 1: `eret` flush pulse.
- `epc_i` in 32: return address for `eret`.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, bits [1:0] always 00.
- `imem_ack_i` in 1: response valid this cycle.
- `imem_rdata_i` in 32: instruction word.
- `ifid_valid_o` out 1: IF/ID holds a real instruction.
- `ifid_instr_o` out 32: IF/ID instruction.
- `ifid_pc4_o` out 32: fetch PC + 4 of the IF/ID instruction.
- `pc_o` out 32: current fetch PC.

## Operation
- FSM states: RST, FETCH, HOLD, DRAIN.
- RST is the reset state. The FSM leaves it on the first clock after reset deasserts and moves to FETCH with `pc=RESET_PC`.
- FETCH: `imem_req_o=1`, `imem_addr_o={pc[31:2],2'b00}`. The request stays high and the address stays stable until `imem_ack_i`.
- On ack with `stall_i=0`:
  - IF/ID loads `{1, rdata, pc+4}`.
  - `pc` advances to `pc_next`.
  - The FSM stays in FETCH.
- On ack with `stall_i=1`:
  - `rdata` and `pc+4` go to a skid register.
  - The FSM enters HOLD with `imem_req_o=0`.
- HOLD: when `stall_i` drops, IF/ID loads from the skid register, `pc` advances to `pc_next`, and the FSM returns to FETCH.
- While `stall_i=1`, IF/ID and `pc` do not change, regardless of state.
- `pc_next` is the pending redirect target when one is armed, otherwise `pc+4`. Using it clears the armed redirect.
- Redirect and delay slot:
  - `redir_valid_i` arms `pend_pc<=redir_pc_i`.
  - The fetch in flight or next delivered is the delay slot. It is always delivered.
  - The fetch that follows the delay slot uses `pend_pc`.
- Flush: `exc_valid_i` or `eret_valid_i`.
  - Priority: exc > eret > redirect.
  - `ifid_valid_o<=0`, the skid register is invalidated, and the pending redirect is cleared.
  - `pc<=EXC_PC` or `epc_i`.
  - With no request outstanding, the FSM goes to FETCH at the new pc.
  - With a request outstanding (`req=1`, no ack yet), the FSM enters DRAIN and holds the request until ack, then discards the data and goes to FETCH.
  - A flush in the same cycle as an ack also discards that data.
- Flush overrides `stall_i`.
- A redirect arriving during DRAIN or in the flush cycle is ignored.
- A second `redir_valid_i` while one is already armed replaces `pend_pc`; the last one wins.
- `pc` arithmetic is modulo 2^32: 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - `pc_o=RESET_PC`, `imem_req_o=0`, `imem_addr_o=RESET_PC`.
  - `ifid_valid_o=0`, `ifid_instr_o=0`, `ifid_pc4_o=0`.
  - Pending redirect and skid register cleared.
- Reset asserted mid-fetch forces the RST state immediately, and the outstanding ack is not waited for.
- First `imem_req_o` is high in the first cycle after reset deasserts.
- Throughput is 1 instruction/cycle when ack returns in the request cycle.
- Fetch-to-IF/ID latency is 1 cycle after the ack edge.
- Redirect takes effect on the second `imem_addr_o` after `redir_valid_i`, counting the delay-slot fetch.
- Flush: the first fetch at the new pc is in the cycle after the flush with no request outstanding, or in the cycle after the drain ack otherwise.
- All outputs are registered; there is no combinational path from inputs to `imem_req_o` or `imem_addr_o`.

## Test plan
- Reset, 0-wait ack:
  - `imem_addr_o` sequence 0x3000, 0x3004, 0x3008.
  - IF/ID pc4 values 0x3004, 0x3008, …, one per cycle.
- `stall_i` high 3 cycles with ack in the first of them:
  - IF/ID is unchanged for 3 cycles and no new request is issued.
  - After release, the skid instruction appears and fetch resumes at +4.
- Redirect from a branch at 0x3008 with `redir_pc_i`=0x3100:
  - Fetch order 0x300C (delay slot, delivered), then 0x3100, 0x3104.
- Exception while a request to 0x3010 waits 2 cycles for ack:
  - The state is DRAIN and `ifid_valid_o`=0.
  - The 0x3010 data is dropped and the next fetch is 0x4180.
- Simultaneous `exc_valid_i`, `eret_valid_i` (`epc_i`=0x3020) and `redir_valid_i`:
  - Next fetch is 0x4180 and the redirect is discarded.
- `rst_n` pulsed low while `imem_req_o`=1 mid-wait:
  - All outputs return to their reset values asynchronously.
  - Fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// fills IF/ID, and handles stalls, delay-slot redirects and exception/eret flushes.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_pc_i,
  input  logic        exc_valid_i,
  input  logic        eret_valid_i,
  input  logic [31:0] epc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        advance;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  assign flush    = exc_valid_i | eret_valid_i;
  assign flush_pc = exc_valid_i ? EXC_PC : epc_i;
  assign pc_plus4 = pc_q + 32'd4;

  // A redirect arriving in the same cycle the delay slot completes is used directly.
  always_comb begin
    pc_next = pc_plus4;
    if (redir_valid_i) begin
      pc_next = redir_pc_i;
    end else if (pend_valid_q) begin
      pc_next = pend_pc_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    advance      = 1'b0;

    if (flush) begin
      pc_d         = flush_pc;
      pend_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
      // An unacknowledged request must still complete before the new address goes out.
      if ((state_q == FETCH || state_q == DRAIN) && !imem_ack_i) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
        addr_d  = word_align(flush_pc);
      end
    end else begin
      case (state_q)
        RST: begin
          state_d = FETCH;
          pc_d    = RESET_PC;
          addr_d  = word_align(RESET_PC);
        end
        FETCH: begin
          if (imem_ack_i) begin
            if (stall_i) begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata_i;
              skid_pc4_d   = pc_plus4;
              state_d      = HOLD;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata_i;
              ifid_pc4_d   = pc_plus4;
              advance      = 1'b1;
            end
          end else if (!stall_i) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_valid_d = skid_valid_q;
            ifid_instr_d = skid_instr_q;
            ifid_pc4_d   = skid_pc4_q;
            skid_valid_d = 1'b0;
            advance      = 1'b1;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            state_d = FETCH;
            addr_d  = word_align(pc_q);
          end
        end
        default: begin
          state_d = RST;
        end
      endcase

      if (advance) begin
        pc_d         = pc_next;
        addr_d       = word_align(pc_next);
        pend_valid_d = 1'b0;
      end else if (redir_valid_i && state_q != DRAIN) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = redir_pc_i;
      end
    end

    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST;
      pc_q         <= RESET_PC;
      addr_q       <= word_align(RESET_PC);
      req_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios with fixed expected addresses, then a
// randomized run checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redir_valid_i;
  logic [31:0] redir_pc_i;
  logic        exc_valid_i;
  logic        eret_valid_i;
  logic [31:0] epc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] pc_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redir_valid_i(redir_valid_i),
    .redir_pc_i   (redir_pc_i),
    .exc_valid_i  (exc_valid_i),
    .eret_valid_i (eret_valid_i),
    .epc_i        (epc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .ifid_valid_o (ifid_valid_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .pc_o         (pc_o)
  );

  // Instruction memory contents: a scrambled function of the word address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    imem_rdata_i = imem_ack_i ? instr_of(imem_addr_o) : 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; redir_valid_i = 1'b0; redir_pc_i = 32'h0;
    exc_valid_i = 1'b0; eret_valid_i = 1'b0; epc_i = 32'h0;
    imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
    @(negedge clk); @(negedge clk);
    checks++; if (pc_o !== RESET_PC) begin failures++; $display("[TB] FAIL rst_pc: got %h want %h", pc_o, RESET_PC); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== RESET_PC) begin failures++; $display("[TB] FAIL rst_addr: got %h want %h", imem_addr_o, RESET_PC); end
    checks++; if (ifid_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b want 0", ifid_valid_o); end
    checks++; if (ifid_instr_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_instr: got %h want 0", ifid_instr_o); end
    checks++; if (ifid_pc4_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_pc4: got %h want 0", ifid_pc4_o); end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin failures++; $display("[TB] FAIL rst_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    imem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = RESET_PC + 32'(4 * i);
      checks++; if (imem_addr_o !== a) begin failures++; $display("[TB] FAIL zw_addr: got %h want %h", imem_addr_o, a); end
      step();
      checks++;
      if (ifid_valid_o !== 1'b1 || ifid_instr_o !== instr_of(a) || ifid_pc4_o !== a + 32'd4) begin
        failures++; $display("[TB] FAIL zw_ifid: got v=%b i=%h pc4=%h want v=1 i=%h pc4=%h", ifid_valid_o, ifid_instr_o, ifid_pc4_o, instr_of(a), a + 32'd4);
      end
    end
  endtask

  task automatic test_redirect();
    // Branch at 0x3008 sits in IF/ID; 0x300C is the delay slot being fetched.
    checks++; if (imem_addr_o !== 32'h300C) begin failures++; $display("[TB] FAIL redir_slot_addr: got %h want 300c", imem_addr_o); end
    imem_ack_i = 1'b1; redir_valid_i = 1'b1; redir_pc_i = 32'h3100;
    step();
    redir_valid_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h3010 || ifid_instr_o !== instr_of(32'h300C)) begin failures++; $display("[TB] FAIL redir_slot_delivered: got v=%b pc4=%h want v=1 pc4=3010", ifid_valid_o, ifid_pc4_o); end
    checks++; if (imem_addr_o !== 32'h3100) begin failures++; $display("[TB] FAIL redir_target: got %h want 3100", imem_addr_o); end
    step();
    checks++; if (ifid_pc4_o !== 32'h3104 || imem_addr_o !== 32'h3104) begin failures++; $display("[TB] FAIL redir_follow: got pc4=%h addr=%h want 3104/3104", ifid_pc4_o, imem_addr_o); end
    // Delay slot still in flight when the redirect arrives.
    imem_ack_i = 1'b0; redir_valid_i = 1'b1; redir_pc_i = 32'h3200;
    step();
    redir_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h3104 || ifid_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL redir_wait: got addr=%h v=%b want 3104/0", imem_addr_o, ifid_valid_o); end
    imem_ack_i = 1'b1;
    step();
    checks++; if (ifid_pc4_o !== 32'h3108 || imem_addr_o !== 32'h3200) begin failures++; $display("[TB] FAIL redir_late: got pc4=%h addr=%h want 3108/3200", ifid_pc4_o, imem_addr_o); end
    // Two redirects before the delay slot completes: the later target wins.
    imem_ack_i = 1'b0; redir_valid_i = 1'b1; redir_pc_i = 32'h3300;
    step();
    redir_pc_i = 32'h3400;
    step();
    redir_valid_i = 1'b0; imem_ack_i = 1'b1;
    step();
    checks++; if (ifid_pc4_o !== 32'h3204 || imem_addr_o !== 32'h3400) begin failures++; $display("[TB] FAIL redir_last_wins: got pc4=%h addr=%h want 3204/3400", ifid_pc4_o, imem_addr_o); end
  endtask

  task automatic test_stall();
    imem_ack_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ack_i = 1'b0;
      checks++;
      if (imem_req_o !== 1'b0 || ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h3204 || ifid_instr_o !== instr_of(32'h3200) || pc_o !== 32'h3400) begin
        failures++; $display("[TB] FAIL stall_hold: cycle %0d got req=%b v=%b pc4=%h pc=%h want 0/1/3204/3400", i, imem_req_o, ifid_valid_o, ifid_pc4_o, pc_o);
      end
    end
    stall_i = 1'b0;
    step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_instr_o !== instr_of(32'h3400) || ifid_pc4_o !== 32'h3404) begin failures++; $display("[TB] FAIL stall_skid: got v=%b i=%h pc4=%h want 1/%h/3404", ifid_valid_o, ifid_instr_o, ifid_pc4_o, instr_of(32'h3400)); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3404) begin failures++; $display("[TB] FAIL stall_resume: got req=%b addr=%h want 1/3404", imem_req_o, imem_addr_o); end
    imem_ack_i = 1'b1;
    step();
    checks++; if (ifid_pc4_o !== 32'h3408 || imem_addr_o !== 32'h3408) begin failures++; $display("[TB] FAIL stall_after: got pc4=%h addr=%h want 3408/3408", ifid_pc4_o, imem_addr_o); end
  endtask

  task automatic test_exception_drain();
    imem_ack_i = 1'b1; redir_valid_i = 1'b1; redir_pc_i = 32'h3010;
    step();
    redir_valid_i = 1'b0; imem_ack_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h3010) begin failures++; $display("[TB] FAIL exc_setup: got %h want 3010", imem_addr_o); end
    step();
    exc_valid_i = 1'b1;
    step();
    exc_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h3010 || ifid_valid_o !== 1'b0 || pc_o !== EXC_PC) begin
        failures++; $display("[TB] FAIL exc_drain: cycle %0d got req=%b addr=%h v=%b pc=%h want 1/3010/0/4180", i, imem_req_o, imem_addr_o, ifid_valid_o, pc_o);
      end
      if (i == 0) step();
    end
    imem_ack_i = 1'b1;
    step();
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== EXC_PC || imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL exc_discard: got v=%b addr=%h req=%b want 0/4180/1", ifid_valid_o, imem_addr_o, imem_req_o); end
    step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h4184 || ifid_instr_o !== instr_of(EXC_PC) || imem_addr_o !== 32'h4184) begin failures++; $display("[TB] FAIL exc_handler: got v=%b pc4=%h addr=%h want 1/4184/4184", ifid_valid_o, ifid_pc4_o, imem_addr_o); end
  endtask

  task automatic test_flush_priority();
    exc_valid_i = 1'b1; eret_valid_i = 1'b1; epc_i = 32'h3020;
    redir_valid_i = 1'b1; redir_pc_i = 32'h3100; imem_ack_i = 1'b1;
    step();
    exc_valid_i = 1'b0; eret_valid_i = 1'b0; redir_valid_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== EXC_PC || pc_o !== EXC_PC) begin failures++; $display("[TB] FAIL prio_target: got v=%b addr=%h pc=%h want 0/4180/4180", ifid_valid_o, imem_addr_o, pc_o); end
    step();
    checks++; if (ifid_pc4_o !== 32'h4184 || imem_addr_o !== 32'h4184) begin failures++; $display("[TB] FAIL prio_no_redir: got pc4=%h addr=%h want 4184/4184", ifid_pc4_o, imem_addr_o); end
    // eret alone with a request outstanding.
    imem_ack_i = 1'b0; eret_valid_i = 1'b1; epc_i = 32'h3020;
    step();
    eret_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h4184 || pc_o !== 32'h3020) begin failures++; $display("[TB] FAIL eret_drain: got addr=%h pc=%h want 4184/3020", imem_addr_o, pc_o); end
    imem_ack_i = 1'b1;
    step();
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h3020) begin failures++; $display("[TB] FAIL eret_addr: got v=%b addr=%h want 0/3020", ifid_valid_o, imem_addr_o); end
    step();
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h3024 || imem_addr_o !== 32'h3024) begin failures++; $display("[TB] FAIL eret_fetch: got v=%b pc4=%h addr=%h want 1/3024/3024", ifid_valid_o, ifid_pc4_o, imem_addr_o); end
    // Flush while parked with a skid entry: overrides the stall and kills the entry.
    stall_i = 1'b1;
    step();
    imem_ack_i = 1'b0; exc_valid_i = 1'b1;
    step();
    exc_valid_i = 1'b0;
    checks++; if (ifid_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== EXC_PC) begin failures++; $display("[TB] FAIL hold_flush: got v=%b req=%b addr=%h want 0/1/4180", ifid_valid_o, imem_req_o, imem_addr_o); end
    stall_i = 1'b0;
    step();
    checks++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== EXC_PC) begin failures++; $display("[TB] FAIL hold_skid_killed: got v=%b addr=%h want 0/4180", ifid_valid_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    imem_ack_i = 1'b1; redir_valid_i = 1'b1; redir_pc_i = 32'hFFFF_FFFC;
    step();
    redir_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", imem_addr_o); end
    step();
    checks++; if (ifid_pc4_o !== 32'h0 || imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("[TB] FAIL wrap_zero: got pc4=%h addr=%h pc=%h want 0/0/0", ifid_pc4_o, imem_addr_o, pc_o); end
  endtask

  task automatic test_reset_midwait();
    imem_ack_i = 1'b0;
    step();
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre: got req=%b want 1", imem_req_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc_o !== RESET_PC || imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin
      failures++; $display("[TB] FAIL midrst_async: got pc=%h req=%b addr=%h v=%b i=%h pc4=%h", pc_o, imem_req_o, imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc4_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin failures++; $display("[TB] FAIL midrst_restart: got req=%b addr=%h want 1/3000", imem_req_o, imem_addr_o); end
    imem_ack_i = 1'b1;
    step();
    checks++; if (ifid_pc4_o !== 32'h3004 || imem_addr_o !== 32'h3004) begin failures++; $display("[TB] FAIL midrst_fetch: got pc4=%h addr=%h want 3004/3004", ifid_pc4_o, imem_addr_o); end
  endtask

  task automatic test_random();
    logic [31:0] exp_addr, pend_pc, pv_instr, pv_pc4, want_pc4, want_instr;
    logic        pend_v, drain, in_req, flush, pv_valid, want_valid;
    int          wait_left, kind;
    logic [31:0] q_pc4[$];
    logic [31:0] q_instr[$];

    imem_ack_i = 1'b0; stall_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_addr = RESET_PC; pend_v = 1'b0; pend_pc = 32'h0; drain = 1'b0;
    in_req = 1'b0; wait_left = 0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 39);
      exc_valid_i  = (kind == 0);
      eret_valid_i = (kind == 1);
      epc_i = $urandom & 32'hFFFF_FFFC;
      flush = exc_valid_i | eret_valid_i;
      if (imem_req_o) begin
        if (!in_req) begin in_req = 1'b1; wait_left = $urandom_range(0, 2); end
        imem_ack_i = (wait_left == 0);
        if (wait_left != 0) wait_left--;
      end else begin
        imem_ack_i = 1'b0;
      end
      redir_valid_i = !stall_i && (q_pc4.size() == 0) && ($urandom_range(0, 5) == 0);
      redir_pc_i = $urandom & 32'hFFFF_FFFC;

      // Reference: fetches complete in program order; a redirect retargets the
      // fetch after the next completed one; a flush restarts the stream.
      if (redir_valid_i && !drain) begin pend_v = 1'b1; pend_pc = redir_pc_i; end
      if (imem_ack_i) begin
        in_req = 1'b0;
        if (drain) begin
          drain = 1'b0;
        end else if (!flush) begin
          checks++; if (imem_addr_o !== exp_addr) begin failures++; $display("[TB] FAIL rnd_addr: cycle %0d got %h want %h", cyc, imem_addr_o, exp_addr); end
          q_pc4.push_back(exp_addr + 32'd4);
          q_instr.push_back(instr_of(exp_addr));
          exp_addr = pend_v ? pend_pc : exp_addr + 32'd4;
          pend_v = 1'b0;
        end
      end
      if (flush) begin
        q_pc4.delete(); q_instr.delete();
        pend_v = 1'b0;
        exp_addr = exc_valid_i ? EXC_PC : epc_i;
        drain = imem_req_o && !imem_ack_i;
      end

      pv_valid = ifid_valid_o; pv_instr = ifid_instr_o; pv_pc4 = ifid_pc4_o;
      step();

      if (flush) begin
        checks++; if (ifid_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rnd_flush: cycle %0d got v=%b want 0", cyc, ifid_valid_o); end
      end else if (stall_i) begin
        checks++;
        if (ifid_valid_o !== pv_valid || ifid_instr_o !== pv_instr || ifid_pc4_o !== pv_pc4) begin
          failures++; $display("[TB] FAIL rnd_stall: cycle %0d got v=%b pc4=%h want v=%b pc4=%h", cyc, ifid_valid_o, ifid_pc4_o, pv_valid, pv_pc4);
        end
      end else begin
        want_valid = (q_pc4.size() != 0);
        checks++; if (ifid_valid_o !== want_valid) begin failures++; $display("[TB] FAIL rnd_valid: cycle %0d got %b want %b", cyc, ifid_valid_o, want_valid); end
        if (want_valid) begin
          want_pc4 = q_pc4.pop_front();
          want_instr = q_instr.pop_front();
          checks++;
          if (ifid_pc4_o !== want_pc4 || ifid_instr_o !== want_instr) begin
            failures++; $display("[TB] FAIL rnd_ifid: cycle %0d got pc4=%h i=%h want pc4=%h i=%h", cyc, ifid_pc4_o, ifid_instr_o, want_pc4, want_instr);
          end
        end
      end
    end
    stall_i = 1'b0; exc_valid_i = 1'b0; eret_valid_i = 1'b0; redir_valid_i = 1'b0; imem_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_redirect();
    test_stall();
    test_exception_drain();
    test_flush_priority();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
